// File: rtl/fmc_pkg.sv
// Shared types for the FMC burst bridge: FSM states, burst direction, latency bound.
package fmc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATENCY,
        ST_DATA,
        ST_DRAIN
    } fmc_state_t;

    typedef enum logic {
        FMC_READ,
        FMC_WRITE
    } fmc_dir_t;

    localparam int MaxLatency = 15;

endpackage

// File: rtl/fmc_data_bus.sv
// Tristate driver for the multiplexed FMC address/data pins.
module fmc_data_bus #(
    parameter int DataWidth = 16
) (
    input  logic                 drive,
    input  logic [DataWidth-1:0] dout,
    output logic [DataWidth-1:0] din,
    inout  wire  [DataWidth-1:0] data_io
);

    logic tristate_out;

    assign tristate_out = !drive;
    assign data_io      = tristate_out ? {DataWidth{1'bz}} : dout;
    assign din          = data_io;

endmodule

// File: rtl/fmc_burst_bridge.sv
// Synchronous multiplexed FMC (PSRAM-mode) slave bridging bursts onto a req/gnt/rvalid backend.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for an address phase (cs + adv low)
// ST_LATENCY | counting latency clocks before the first data beat
// ST_DATA    | beats transfer; wait_o holds the master when not ready
// ST_DRAIN   | burst ended with a read in flight; discard its rvalid
module fmc_burst_bridge
    import fmc_pkg::*;
#(
    parameter int AddrWidth = 16,
    parameter int DataWidth = 16,
    parameter int Latency   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    inout  wire  [DataWidth-1:0]   data_io,
    input  logic                   cs_ni,
    input  logic                   oe_ni,
    input  logic                   we_ni,
    input  logic                   adv_ni,
    input  logic [DataWidth/8-1:0] nbl_ni,
    output logic                   wait_o,
    output logic                   req_o,
    output logic                   we_o,
    output logic [AddrWidth-1:0]   addr_o,
    output logic [DataWidth-1:0]   wdata_o,
    output logic [DataWidth/8-1:0] be_o,
    input  logic                   gnt_i,
    input  logic                   rvalid_i,
    input  logic [DataWidth-1:0]   rdata_i
);

    localparam int BeWidth  = DataWidth / 8;
    localparam int CntWidth = $clog2(MaxLatency + 1);

    fmc_state_t           state_q, state_d;
    fmc_dir_t             dir_q;
    logic [CntWidth-1:0]  cnt_q;
    logic [AddrWidth-1:0] addr_q;
    logic                 req_q, we_q, rd_busy_q, rd_valid_q;
    logic [DataWidth-1:0] wdata_q, rd_out_q, bus_in;
    logic [BeWidth-1:0]   be_q;
    logic                 grant, wr_pend, in_burst, addr_hit, burst_end;
    logic                 drain_needed, wr_beat, rd_beat, drive;

    fmc_data_bus #(.DataWidth(DataWidth)) u_data_bus (
        .drive   (drive),
        .dout    (rd_out_q),
        .din     (bus_in),
        .data_io (data_io)
    );

    assign grant    = req_q & gnt_i;
    assign wr_pend  = req_q & we_q;
    assign in_burst = (state_q == ST_LATENCY) || (state_q == ST_DATA);
    // A new address is only taken once the backend has retired the previous
    // burst's last request, so addr_q never moves under a pending request.
    assign addr_hit  = (state_q == ST_IDLE) && !cs_ni && !adv_ni && !req_q;
    assign burst_end = in_burst && cs_ni;
    assign drain_needed = (dir_q == FMC_READ) && (req_q || (rd_busy_q && !rvalid_i));
    assign wr_beat = (state_q == ST_DATA) && (dir_q == FMC_WRITE) && !cs_ni && !we_ni && !wait_o;
    assign rd_beat = (state_q == ST_DATA) && (dir_q == FMC_READ) && !cs_ni && !oe_ni && rd_valid_q;
    assign drive   = (state_q == ST_DATA) && (dir_q == FMC_READ) && !cs_ni && !oe_ni;

    assign req_o   = req_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign be_o    = be_q;

    // Next-state decode and the wait_o handshake.
    always_comb begin
        state_d = state_q;
        wait_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (addr_hit) state_d = (Latency == 1) ? ST_DATA : ST_LATENCY;
            end
            ST_LATENCY: begin
                if (cs_ni)                         state_d = drain_needed ? ST_DRAIN : ST_IDLE;
                else if (cnt_q == CntWidth'(1))    state_d = ST_DATA;
            end
            ST_DATA: begin
                if (dir_q == FMC_WRITE) wait_o = wr_pend & ~gnt_i;
                else                    wait_o = ~rd_valid_q;
                if (cs_ni) state_d = drain_needed ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (!req_q && (!rd_busy_q || rvalid_i)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, address counter, backend request register and read buffer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            dir_q      <= FMC_READ;
            cnt_q      <= '0;
            addr_q     <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            rd_busy_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            wdata_q    <= '0;
            rd_out_q   <= '0;
            be_q       <= '0;
        end else begin
            state_q <= state_d;
            if (grant) req_q <= 1'b0;
            if (addr_hit) begin
                addr_q     <= bus_in[AddrWidth-1:0];
                dir_q      <= we_ni ? FMC_READ : FMC_WRITE;
                cnt_q      <= CntWidth'(Latency - 1);
                rd_valid_q <= 1'b0;
                if (we_ni) begin
                    req_q <= 1'b1;
                    we_q  <= 1'b0;
                    be_q  <= '1;
                end
            end
            if (state_q == ST_LATENCY) cnt_q <= cnt_q - CntWidth'(1);
            if (wr_beat) begin
                req_q   <= 1'b1;
                we_q    <= 1'b1;
                wdata_q <= bus_in;
                be_q    <= ~nbl_ni;
            end
            if (grant && we_q)  addr_q    <= addr_q + AddrWidth'(1);
            if (grant && !we_q) rd_busy_q <= 1'b1;
            if (rvalid_i) begin
                rd_busy_q <= 1'b0;
                if (in_burst && !cs_ni) begin
                    rd_out_q   <= rdata_i;
                    rd_valid_q <= 1'b1;
                end
            end
            if (rd_beat) begin
                rd_valid_q <= 1'b0;
                addr_q     <= addr_q + AddrWidth'(1);
                req_q      <= 1'b1;
                we_q       <= 1'b0;
                be_q       <= '1;
            end
            if (burst_end) rd_valid_q <= 1'b0;
        end
    end

endmodule
